// File: rtl/issue_scoreboard_if.sv
// Decode/execute-side signal bundle for the issue scoreboard.
// The master side (decode stage / bench) drives instruction, writeback and
// branch-resolution inputs. The slave side (the scoreboard) returns the
// issue/stall/flush controls and its state.
interface issue_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int REG_SEL  = $clog2(NUM_REGS),
    parameter int CNT_W    = 4
);
    logic                id_valid;
    logic [REG_SEL-1:0]  id_rs1;
    logic [REG_SEL-1:0]  id_rs2;
    logic                id_uses_rs1;
    logic                id_uses_rs2;
    logic [REG_SEL-1:0]  id_destination;
    logic                id_write_reg;
    logic                id_branch;
    logic                ex_ready;
    logic                wb_valid;
    logic [REG_SEL-1:0]  wb_rd;
    logic                br_resolve;
    logic                br_taken;

    logic                issue;
    logic                stall_if;
    logic                flush;
    logic [NUM_REGS-1:0] busy_mask;
    logic [CNT_W-1:0]    outstanding;
    logic [1:0]          state;
    logic                err;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_destination, id_write_reg, id_branch, ex_ready,
               wb_valid, wb_rd, br_resolve, br_taken,
        input  issue, stall_if, flush, busy_mask, outstanding, state, err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_destination, id_write_reg, id_branch, ex_ready,
               wb_valid, wb_rd, br_resolve, br_taken,
        output issue, stall_if, flush, busy_mask, outstanding, state, err
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue controller between decode and execute.
// Keeps a per-register busy bit for every in-flight writer, interlocks
// RAW/WAW hazards against that registered mask, caps the number of
// in-flight writers, and sequences branch resolution (hold fetch until the
// outcome is known, then squash the front end for FLUSH_CYCLES on taken).
module issue_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int REG_SEL      = $clog2(NUM_REGS),
    parameter int MAX_OUT      = 4,
    parameter int CNT_W        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    issue_scoreboard_if.slave bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    logic [NUM_REGS-1:0] r_busy;
    logic [CNT_W-1:0]    r_outstanding;
    state_t              r_state;
    logic [2:0]          r_flush_cnt;
    logic                r_flush;
    logic                r_err;

    logic [REG_SEL-1:0]  w_rs1;
    logic [REG_SEL-1:0]  w_rs2;
    logic [REG_SEL-1:0]  w_rd;
    logic [REG_SEL-1:0]  w_wb_rd;
    logic                w_wr;
    logic                w_hazard;
    logic                w_full;
    logic                w_issue;
    logic                w_wb_live;
    logic                w_set;
    logic                w_clr;
    logic                w_wb_err;
    logic [NUM_REGS-1:0] w_set_vec;
    logic [NUM_REGS-1:0] w_clr_vec;

    assign w_rs1   = bus.id_rs1;
    assign w_rs2   = bus.id_rs2;
    assign w_rd    = bus.id_destination;
    assign w_wb_rd = bus.wb_rd;

    // x0 is hardwired: it is never a hazard source and never tracked.
    assign w_wr = bus.id_write_reg & (w_rd != '0);

    // Hazards look only at the registered mask; a same-cycle writeback is
    // not bypassed, so the dependent instruction issues one cycle later.
    assign w_hazard = (bus.id_uses_rs1 & (w_rs1 != '0) & r_busy[w_rs1])
                    | (bus.id_uses_rs2 & (w_rs2 != '0) & r_busy[w_rs2])
                    | (w_wr & r_busy[w_rd]);

    assign w_full  = (r_outstanding == CNT_W'(MAX_OUT));
    assign w_issue = bus.id_valid & bus.ex_ready & (r_state == RUN)
                   & ~w_hazard & ~(w_wr & w_full);

    // A writeback to a register with no pending writer is a protocol error
    // and must not disturb the mask or the counter.
    assign w_wb_live = bus.wb_valid & (w_wb_rd != '0);
    assign w_set     = w_issue & w_wr;
    assign w_clr     = w_wb_live & r_busy[w_wb_rd];
    assign w_wb_err  = w_wb_live & ~r_busy[w_wb_rd];

    assign w_set_vec = w_set ? (NUM_REGS'(1) << w_rd)    : '0;
    assign w_clr_vec = w_clr ? (NUM_REGS'(1) << w_wb_rd) : '0;

    // Scoreboard, writer count and sticky error; a set lands after the
    // clear so it wins when both hit the same register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy        <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
            case ({w_set, w_clr})
                2'b10: if (!w_full)              r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01: if (r_outstanding != '0)  r_outstanding <= r_outstanding - CNT_W'(1);
                default: ;
            endcase
            if (w_wb_err) r_err <= 1'b1;
        end
    end

    // Branch sequencing FSM; flush is a registered output that is high for
    // exactly the FLUSH_CYCLES cycles spent in FLUSH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
            r_flush     <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_issue && bus.id_branch) r_state <= BR_WAIT;
                end
                BR_WAIT: begin
                    if (bus.br_resolve) begin
                        if (bus.br_taken) begin
                            r_state     <= FLUSH;
                            r_flush_cnt <= 3'(FLUSH_CYCLES - 1);
                            r_flush     <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_state <= RUN;
                        r_flush <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign bus.issue       = w_issue;
    assign bus.stall_if    = (r_state != RUN) | (bus.id_valid & ~w_issue);
    assign bus.flush       = r_flush;
    assign bus.busy_mask   = r_busy;
    assign bus.outstanding = r_outstanding;
    assign bus.state       = r_state;
    assign bus.err         = r_err;

endmodule
